// File: rtl/centroid_uart_tx.sv
// Transmit end of the inter-FPGA centroid link: frames a (z, y) sample into a
// 5-byte packet (sync, z hi, z lo, y, xor check) and shifts it out as 8N1 UART.
module centroid_uart_tx #(
  parameter int          Z_WIDTH      = 9,
  parameter int          Y_WIDTH      = 8,
  parameter int          BAUD_DIVISOR = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [Z_WIDTH-1:0] z_in,
  input  logic [Y_WIDTH-1:0] y_in,
  input  logic               valid_in,
  output logic               tx_out,
  output logic               busy_out,
  output logic               packet_done_out,
  output logic               overwrite_out
);

  localparam int CW = (BAUD_DIVISOR > 2) ? $clog2(BAUD_DIVISOR) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIVISOR - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      baud_cnt;
  logic [2:0]         bit_idx;
  logic [2:0]         byte_idx;
  logic [Z_WIDTH-1:0] z_hold;
  logic [Y_WIDTH-1:0] y_hold;
  logic               pending;
  logic [7:0]         pkt [0:4];
  logic               done_q;
  logic               overwrite_q;

  logic               baud_last;
  logic               load;
  logic               last_stop;
  logic [15:0]        z_ext;
  logic [7:0]         y_ext;
  logic [7:0]         cur_byte;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign load      = (state == IDLE) && pending;
  assign last_stop = (state == STOP) && baud_last && (byte_idx == 3'd4);

  always_comb begin
    z_ext = '0;
    y_ext = '0;
    z_ext[Z_WIDTH-1:0] = z_hold;
    y_ext[Y_WIDTH-1:0] = y_hold;
  end

  always_comb begin
    cur_byte = 8'hFF;
    case (byte_idx)
      3'd0:    cur_byte = pkt[0];
      3'd1:    cur_byte = pkt[1];
      3'd2:    cur_byte = pkt[2];
      3'd3:    cur_byte = pkt[3];
      3'd4:    cur_byte = pkt[4];
      default: cur_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (pending) state_next = START;
      START: if (baud_last) state_next = DATA;
      DATA:  if (baud_last && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (baud_last) state_next = (byte_idx == 3'd4) ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_out = 1'b1;
    case (state)
      START:   tx_out = 1'b0;
      DATA:    tx_out = cur_byte[bit_idx];
      default: tx_out = 1'b1;
    endcase
  end

  assign busy_out        = (state != IDLE);
  assign packet_done_out = done_q;
  assign overwrite_out   = overwrite_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      z_hold      <= '0;
      y_hold      <= '0;
      pending     <= 1'b0;
      done_q      <= 1'b0;
      overwrite_q <= 1'b0;
      for (int i = 0; i < 5; i++) pkt[i] <= '0;
    end else begin
      state       <= state_next;
      done_q      <= last_stop;
      // A strobe coinciding with a load is a fresh sample, not a replacement.
      overwrite_q <= valid_in && pending && !load;

      if (valid_in) begin
        z_hold  <= z_in;
        y_hold  <= y_in;
        pending <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end

      if (load) begin
        pkt[0]   <= SYNC_BYTE;
        pkt[1]   <= z_ext[15:8];
        pkt[2]   <= z_ext[7:0];
        pkt[3]   <= y_ext;
        pkt[4]   <= z_ext[15:8] ^ z_ext[7:0] ^ y_ext;
        baud_cnt <= '0;
        bit_idx  <= '0;
        byte_idx <= '0;
      end else if (state != IDLE) begin
        baud_cnt <= baud_last ? '0 : baud_cnt + CW'(1);
        if (baud_last && state == DATA) bit_idx <= bit_idx + 3'd1;
        if (baud_last && state == STOP) byte_idx <= byte_idx + 3'd1;
      end
    end
  end

endmodule
